// File: rtl/game_ctrl_fsm.sv
// Game-state controller: START/PLAYING/PAUSE/RESET/GAMEOVER plus timed RESPAWN and LEVELUP,
// with life counting, level progression and rising-edge detection on the start/pause buttons.
module game_ctrl_fsm #(
  parameter int LIVES    = 3,
  parameter int LIVES_W  = 2,
  parameter int LEVELS   = 4,
  parameter int LEVEL_W  = 2,
  parameter int HOLD_CYC = 16,
  parameter int HOLD_W   = 5
) (
  input  logic               clk,
  input  logic               resetFSM,
  input  logic               startGame,
  input  logic               pauseGame,
  input  logic               reset,
  input  logic               dead,
  input  logic               levelDone,
  output logic [2:0]         dataout,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic               win,
  output logic               running
);

  typedef enum logic [2:0] {
    ST_START    = 3'b000,
    ST_PLAYING  = 3'b001,
    ST_PAUSE    = 3'b010,
    ST_RESET    = 3'b011,
    ST_GAMEOVER = 3'b100,
    ST_RESPAWN  = 3'b101,
    ST_LEVELUP  = 3'b110
  } state_t;

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(LEVELS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

  state_t               state_r, state_n;
  logic [LIVES_W-1:0]   lives_r, lives_n;
  logic [LEVEL_W-1:0]   level_r, level_n;
  logic                 win_r, win_n;
  logic [HOLD_W-1:0]    hold_r, hold_n;
  logic                 running_r;
  logic                 start_q_r, pause_q_r;
  logic                 start_rise_s, pause_rise_s;

  assign start_rise_s = startGame & ~start_q_r;
  assign pause_rise_s = pauseGame & ~pause_q_r;

  // Next-state and next-counter logic; events outside their owning state are ignored.
  always_comb begin
    state_n = state_r;
    lives_n = lives_r;
    level_n = level_r;
    win_n   = win_r;
    hold_n  = hold_r;
    case (state_r)
      ST_RESET: begin
        state_n = ST_START;
        lives_n = LIVES_INIT;
        level_n = {LEVEL_W{1'b0}};
        win_n   = 1'b0;
        hold_n  = {HOLD_W{1'b0}};
      end
      ST_START: begin
        if (start_rise_s) state_n = ST_PLAYING;
        else              state_n = ST_START;
      end
      ST_PLAYING: begin
        if (reset) begin
          state_n = ST_RESET;
        end else if (pause_rise_s) begin
          state_n = ST_PAUSE;
        end else if (dead) begin
          // dead outranks a coincident levelDone, which is simply dropped
          lives_n = lives_r - LIVES_ONE;
          if (lives_r == LIVES_ONE) begin
            state_n = ST_GAMEOVER;
          end else begin
            state_n = ST_RESPAWN;
            hold_n  = HOLD_LOAD;
          end
        end else if (levelDone) begin
          if (level_r == LEVEL_LAST) begin
            state_n = ST_GAMEOVER;
            win_n   = 1'b1;
          end else begin
            state_n = ST_LEVELUP;
            level_n = level_r + LEVEL_ONE;
            hold_n  = HOLD_LOAD;
          end
        end else begin
          state_n = ST_PLAYING;
        end
      end
      ST_PAUSE: begin
        if (reset)             state_n = ST_RESET;
        else if (pause_rise_s) state_n = ST_PLAYING;
        else                   state_n = ST_PAUSE;
      end
      ST_RESPAWN, ST_LEVELUP: begin
        if (reset) begin
          state_n = ST_RESET;
        end else if (hold_r == {HOLD_W{1'b0}}) begin
          state_n = ST_PLAYING;
        end else begin
          state_n = state_r;
          hold_n  = hold_r - HOLD_ONE;
        end
      end
      ST_GAMEOVER: begin
        if (start_rise_s || reset) state_n = ST_RESET;
        else                       state_n = ST_GAMEOVER;
      end
      default: begin
        state_n = ST_RESET;
      end
    endcase
  end

  // State, counters, button history and registered outputs.
  always_ff @(posedge clk or posedge resetFSM) begin
    if (resetFSM) begin
      state_r   <= ST_RESET;
      lives_r   <= LIVES_INIT;
      level_r   <= {LEVEL_W{1'b0}};
      win_r     <= 1'b0;
      hold_r    <= {HOLD_W{1'b0}};
      running_r <= 1'b0;
      start_q_r <= 1'b0;
      pause_q_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      lives_r   <= lives_n;
      level_r   <= level_n;
      win_r     <= win_n;
      hold_r    <= hold_n;
      running_r <= (state_n == ST_PLAYING);
      start_q_r <= startGame;
      pause_q_r <= pauseGame;
    end
  end

  assign dataout = state_r;
  assign lives   = lives_r;
  assign level   = level_r;
  assign win     = win_r;
  assign running = running_r;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed self-checking bench for game_ctrl_fsm with default parameters.
module tb_game_ctrl_fsm;

  logic       clk = 1'b0;
  logic       resetFSM = 1'b1;
  logic       startGame = 1'b0;
  logic       pauseGame = 1'b0;
  logic       reset = 1'b0;
  logic       dead = 1'b0;
  logic       levelDone = 1'b0;
  logic [2:0] dataout;
  logic [1:0] lives;
  logic [1:0] level;
  logic       win;
  logic       running;

  int passed = 0;
  int total  = 0;

  game_ctrl_fsm dut (
    .clk(clk), .resetFSM(resetFSM), .startGame(startGame), .pauseGame(pauseGame),
    .reset(reset), .dead(dead), .levelDone(levelDone),
    .dataout(dataout), .lives(lives), .level(level), .win(win), .running(running)
  );

  always #5 clk = ~clk;

  task automatic go_playing();
    startGame = 1'b0; pauseGame = 1'b0; reset = 1'b0; dead = 1'b0; levelDone = 1'b0;
    resetFSM = 1'b1;
    @(negedge clk);
    resetFSM = 1'b0;
    @(negedge clk);
    startGame = 1'b1;
    @(negedge clk);
    startGame = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (dataout !== 3'b011) $display("FAIL reset_state dataout=%b exp=011", dataout); else passed++;
    total++; if (lives !== 2'd3 || level !== 2'd0 || win !== 1'b0 || running !== 1'b0)
      $display("FAIL reset_outputs lives=%0d level=%0d win=%b running=%b exp 3/0/0/0", lives, level, win, running);
    else passed++;
    resetFSM = 1'b0;
    @(negedge clk);
    total++; if (dataout !== 3'b000) $display("FAIL reset_to_start dataout=%b exp=000", dataout); else passed++;
    startGame = 1'b1;
    @(negedge clk);
    startGame = 1'b0;
    total++; if (dataout !== 3'b001 || running !== 1'b1 || lives !== 2'd3 || level !== 2'd0)
      $display("FAIL start_playing dataout=%b running=%b lives=%0d level=%0d exp 001/1/3/0", dataout, running, lives, level);
    else passed++;
  endtask

  task automatic test_pause();
    pauseGame = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (dataout !== 3'b010 || running !== 1'b0)
        $display("FAIL pause_held cyc=%0d dataout=%b running=%b exp 010/0", i, dataout, running);
      else passed++;
    end
    dead = 1'b1;
    @(negedge clk);
    dead = 1'b0;
    total++; if (dataout !== 3'b010 || lives !== 2'd3)
      $display("FAIL pause_dead dataout=%b lives=%0d exp 010/3", dataout, lives);
    else passed++;
    pauseGame = 1'b0;
    @(negedge clk);
    pauseGame = 1'b1;
    @(negedge clk);
    pauseGame = 1'b0;
    total++; if (dataout !== 3'b001 || running !== 1'b1)
      $display("FAIL unpause dataout=%b running=%b exp 001/1", dataout, running);
    else passed++;
  endtask

  task automatic test_life_loss();
    int cnt;
    for (int i = 0; i < 3; i++) begin
      dead = 1'b1;
      @(negedge clk);
      dead = 1'b0;
      if (i < 2) begin
        total++; if (dataout !== 3'b101 || lives !== 2'(2 - i))
          $display("FAIL respawn_enter n=%0d dataout=%b lives=%0d exp 101/%0d", i, dataout, lives, 2 - i);
        else passed++;
        cnt = 0;
        while (dataout === 3'b101 && cnt < 100) begin
          cnt++;
          @(negedge clk);
        end
        total++; if (cnt !== 16 || dataout !== 3'b001)
          $display("FAIL respawn_len n=%0d cycles=%0d dataout=%b exp 16/001", i, cnt, dataout);
        else passed++;
      end else begin
        total++; if (dataout !== 3'b100 || lives !== 2'd0 || win !== 1'b0 || running !== 1'b0)
          $display("FAIL gameover_dead dataout=%b lives=%0d win=%b running=%b exp 100/0/0/0", dataout, lives, win, running);
        else passed++;
      end
    end
  endtask

  task automatic test_gameover_start();
    startGame = 1'b1;
    @(negedge clk);
    total++; if (dataout !== 3'b011) $display("FAIL go_start_reset dataout=%b exp=011", dataout); else passed++;
    @(negedge clk);
    total++; if (dataout !== 3'b000 || lives !== 2'd3)
      $display("FAIL go_start_start dataout=%b lives=%0d exp 000/3", dataout, lives);
    else passed++;
    @(negedge clk);
    total++; if (dataout !== 3'b000) $display("FAIL held_start_no_game dataout=%b exp=000", dataout); else passed++;
    startGame = 1'b0;
    @(negedge clk);
    startGame = 1'b1;
    @(negedge clk);
    startGame = 1'b0;
    total++; if (dataout !== 3'b001) $display("FAIL repress_start dataout=%b exp=001", dataout); else passed++;
  endtask

  task automatic test_levels();
    int cnt;
    go_playing();
    for (int i = 0; i < 4; i++) begin
      levelDone = 1'b1;
      @(negedge clk);
      levelDone = 1'b0;
      if (i < 3) begin
        total++; if (dataout !== 3'b110 || level !== 2'(i + 1))
          $display("FAIL levelup_enter n=%0d dataout=%b level=%0d exp 110/%0d", i, dataout, level, i + 1);
        else passed++;
        cnt = 0;
        while (dataout === 3'b110 && cnt < 100) begin
          cnt++;
          @(negedge clk);
        end
        total++; if (cnt !== 16 || dataout !== 3'b001)
          $display("FAIL levelup_len n=%0d cycles=%0d dataout=%b exp 16/001", i, cnt, dataout);
        else passed++;
      end else begin
        total++; if (dataout !== 3'b100 || win !== 1'b1 || level !== 2'd3 || lives !== 2'd3)
          $display("FAIL gameover_win dataout=%b win=%b level=%0d lives=%0d exp 100/1/3/3", dataout, win, level, lives);
        else passed++;
      end
    end
  endtask

  task automatic test_simultaneous();
    go_playing();
    dead = 1'b1;
    levelDone = 1'b1;
    @(negedge clk);
    dead = 1'b0;
    levelDone = 1'b0;
    total++; if (dataout !== 3'b101 || lives !== 2'd2 || level !== 2'd0)
      $display("FAIL simultaneous dataout=%b lives=%0d level=%0d exp 101/2/0", dataout, lives, level);
    else passed++;
  endtask

  task automatic test_restart();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (dataout !== 3'b011) $display("FAIL restart_reset dataout=%b exp=011", dataout); else passed++;
    @(negedge clk);
    total++; if (dataout !== 3'b000 || lives !== 2'd3 || level !== 2'd0)
      $display("FAIL restart_start dataout=%b lives=%0d level=%0d exp 000/3/0", dataout, lives, level);
    else passed++;
  endtask

  task automatic test_async_abort();
    go_playing();
    dead = 1'b1;
    @(negedge clk);
    dead = 1'b0;
    repeat (3) @(negedge clk);
    resetFSM = 1'b1;
    #1;
    total++; if (dataout !== 3'b011 || lives !== 2'd3 || running !== 1'b0)
      $display("FAIL async_abort dataout=%b lives=%0d running=%b exp 011/3/0", dataout, lives, running);
    else passed++;
    @(negedge clk);
    resetFSM = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_pause();
    test_life_loss();
    test_gameover_start();
    test_levels();
    test_simultaneous();
    test_restart();
    test_async_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
